// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit five-stage core: ISA field positions,
// opcodes, sequencing-controller states and the hazard scoreboard entry.
package core_pkg;

  localparam int REG_COUNT = 8;
  localparam int REG_W     = $clog2(REG_COUNT);

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RS_MSB = 11;
  localparam int RS_LSB = 9;
  localparam int RT_MSB = 8;
  localparam int RT_LSB = 6;
  localparam int RD_MSB = 5;
  localparam int RD_LSB = 3;

  typedef logic [OP_MSB-OP_LSB:0] opcode_t;
  typedef logic [REG_W-1:0]       reg_idx_t;

  localparam opcode_t OP_RFMT = 4'd0;
  localparam opcode_t OP_ADDI = 4'd1;
  localparam opcode_t OP_SLTI = 4'd3;
  localparam opcode_t OP_LW   = 4'd4;
  localparam opcode_t OP_SW   = 4'd5;
  localparam opcode_t OP_BEQ  = 4'd6;
  localparam opcode_t OP_HALT = 4'd15;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    HALT   = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t dest;
    logic     is_load;
    logic     is_halt;
  } sb_entry_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == CNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/instr_regdecode.sv
// Register-usage decode of one instruction: which sources it reads, which
// register it writes, and whether it is a load or a halt.
module instr_regdecode
  import core_pkg::*;
(
  input  logic [15:0]      instr,
  output logic             rd_rs,
  output logic             rd_rt,
  output logic [REG_W-1:0] src1,
  output logic [REG_W-1:0] src2,
  output logic             wr_en,
  output logic [REG_W-1:0] dest,
  output logic             is_load,
  output logic             is_halt
);

  opcode_t op;
  logic    unused_funct;

  assign op           = instr[OP_MSB:OP_LSB];
  assign src1         = instr[RS_MSB:RS_LSB];
  assign src2         = instr[RT_MSB:RT_LSB];
  assign unused_funct = ^instr[RD_LSB-1:0];

  // Immediate-format ALU ops write back into the rs field, loads into rt.
  always_comb begin
    rd_rs   = 1'b0;
    rd_rt   = 1'b0;
    wr_en   = 1'b0;
    dest    = '0;
    is_load = 1'b0;
    is_halt = 1'b0;
    case (op)
      OP_RFMT: begin
        rd_rs = 1'b1;
        rd_rt = 1'b1;
        wr_en = 1'b1;
        dest  = instr[RD_MSB:RD_LSB];
      end
      OP_ADDI, OP_SLTI: begin
        rd_rt = 1'b1;
        wr_en = 1'b1;
        dest  = instr[RS_MSB:RS_LSB];
      end
      OP_LW: begin
        rd_rs   = 1'b1;
        wr_en   = 1'b1;
        dest    = instr[RT_MSB:RT_LSB];
        is_load = 1'b1;
      end
      OP_SW, OP_BEQ: begin
        rd_rs = 1'b1;
        rd_rt = 1'b1;
      end
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes,
// memory-wait freezes and halt, plus saturating stall/flush counters.
module pipeline_ctrl
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id_instr,
  input  logic        id_valid,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_bubble,
  output logic        exma_en,
  output logic        mawb_en,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  ctrl_state_t      state;
  sb_entry_t        ex_sb;
  sb_entry_t        ma_sb;
  sb_entry_t        id_entry;

  logic             id_rd_rs;
  logic             id_rd_rt;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_wr_en;
  logic [REG_W-1:0] id_dest;
  logic             id_is_load;
  logic             id_is_halt;

  logic             load_use;
  logic             running;
  logic             do_flush;
  logic             do_stall;

  instr_regdecode u_decode (
    .instr   (id_instr),
    .rd_rs   (id_rd_rs),
    .rd_rt   (id_rd_rt),
    .src1    (id_src1),
    .src2    (id_src2),
    .wr_en   (id_wr_en),
    .dest    (id_dest),
    .is_load (id_is_load),
    .is_halt (id_is_halt)
  );

  always_comb begin
    id_entry         = '0;
    id_entry.valid   = id_valid;
    id_entry.dest    = id_wr_en ? id_dest : '0;
    id_entry.is_load = id_is_load;
    id_entry.is_halt = id_is_halt;
  end

  // r0 is hard-wired, so a match on register 0 is never a real dependency.
  always_comb begin
    load_use = 1'b0;
    if (id_valid && ex_sb.valid && ex_sb.is_load) begin
      if (id_rd_rs && (id_src1 != '0) && (id_src1 == ex_sb.dest)) load_use = 1'b1;
      if (id_rd_rt && (id_src2 != '0) && (id_src2 == ex_sb.dest)) load_use = 1'b1;
    end
  end

  // The cycle in which memory becomes ready already runs normally, so a freeze
  // costs exactly the busy cycles and a held branch is acted on at release.
  assign running  = (state != HALT) && !mem_busy;
  assign do_flush = running && branch_taken;
  assign do_stall = running && !branch_taken && load_use;

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_bubble = 1'b0;
    exma_en     = 1'b0;
    mawb_en     = 1'b0;
    halted      = 1'b0;
    if (rst) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (state == HALT) begin
      idex_en     = 1'b1;
      idex_bubble = 1'b1;
      exma_en     = 1'b1;
      mawb_en     = 1'b1;
      halted      = 1'b1;
    end else if (running) begin
      idex_en = 1'b1;
      exma_en = 1'b1;
      mawb_en = 1'b1;
      if (do_flush) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (do_stall) begin
        idex_bubble = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      ex_sb     <= '0;
      ma_sb     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (idex_en) begin
        ma_sb <= ex_sb;
        ex_sb <= (idex_bubble || !id_valid) ? '0 : id_entry;
      end
      if (do_flush) flush_cnt <= sat_inc(flush_cnt);
      if (do_stall) stall_cnt <= sat_inc(stall_cnt);
      case (state)
        RUN, FREEZE: begin
          if (mem_busy)                        state <= FREEZE;
          else if (ex_sb.valid && ex_sb.is_halt) state <= HALT;
          else                                 state <= RUN;
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

  // Empty slots carry no stale fields, and a halt only leaves EX on the edge into HALT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (ma_sb.valid || (ma_sb == '0));
      assert (!(ma_sb.valid && ma_sb.is_halt) || (state == HALT));
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, hand-written halt and
// saturation sequences, then random traffic against a behavioural model.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] id_instr;
  logic        id_valid;
  logic        branch_taken;
  logic        mem_busy;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exma_en, mawb_en, halted;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  // Control word: {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exma_en, mawb_en, halted}
  localparam logic [7:0] C_NORM  = 8'b1101_0110;
  localparam logic [7:0] C_RST   = 8'b0010_1000;
  localparam logic [7:0] C_FRZ   = 8'b0000_0000;
  localparam logic [7:0] C_FLUSH = 8'b1111_1110;
  localparam logic [7:0] C_STALL = 8'b0001_1110;
  localparam logic [7:0] C_HALT  = 8'b0001_1111;

  typedef struct {
    logic        rst;
    logic [15:0] instr;
    logic        valid;
    logic        br;
    logic        busy;
    logic [7:0]  ctl;
    logic        chk_cnt;
    logic [15:0] stall;
    logic [15:0] flush;
  } vec_t;

  vec_t vecs[$];

  pipeline_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_bubble  (idex_bubble),
    .exma_en      (exma_en),
    .mawb_en      (mawb_en),
    .halted       (halted),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input int op, input int rs, input int rt, input int rd);
    logic [15:0] w;
    w = {op[3:0], rs[2:0], rt[2:0], rd[2:0], 3'b000};
    return w;
  endfunction

  function automatic void addVec(input logic r, input logic [15:0] ins, input logic v,
                                 input logic b, input logic bz, input logic [7:0] c,
                                 input logic cc, input int s, input int f);
    vec_t e;
    e.rst = r; e.instr = ins; e.valid = v; e.br = b; e.busy = bz;
    e.ctl = c; e.chk_cnt = cc; e.stall = s[15:0]; e.flush = f[15:0];
    vecs.push_back(e);
  endfunction

  // Registers read by an instruction as a bitmask, with r0 removed.
  function automatic logic [7:0] readMask(input logic [15:0] ins);
    logic [7:0] m;
    int op, rs, rt;
    op = int'(ins[15:12]); rs = int'(ins[11:9]); rt = int'(ins[8:6]);
    m = '0;
    if (op == 0 || op == 5 || op == 6) begin m[rs] = 1'b1; m[rt] = 1'b1; end
    else if (op == 1 || op == 3) m[rt] = 1'b1;
    else if (op == 4) m[rs] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic applyStimulus(input logic r, input logic [15:0] ins, input logic v,
                               input logic b, input logic bz);
    @(negedge clk);
    rst = r; id_instr = ins; id_valid = v; branch_taken = b; mem_busy = bz;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] ctl, input logic chk_cnt,
                             input logic [15:0] s, input logic [15:0] f);
    logic [7:0] got;
    got = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exma_en, mawb_en, halted};
    checks++;
    if (got !== ctl) begin
      errors++;
      $display("[TB] FAIL %s ctl: got %b want %b", tag, got, ctl);
    end
    if (chk_cnt) begin
      checks++;
      if (stall_cnt !== s) begin
        errors++;
        $display("[TB] FAIL %s stall_cnt: got %h want %h", tag, stall_cnt, s);
      end
      checks++;
      if (flush_cnt !== f) begin
        errors++;
        $display("[TB] FAIL %s flush_cnt: got %h want %h", tag, flush_cnt, f);
      end
    end
  endtask

  initial begin
    logic [15:0] exp_s, exp_f;
    int          m_halt, m_stall, m_flush;
    logic        m_ex_ok;
    logic [15:0] m_ex;
    logic        r_rst, r_valid, r_br, r_busy, hz;
    logic [15:0] r_instr;
    logic [7:0]  mask, exp_ctl;

    rst = 1'b1; id_instr = '0; id_valid = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;

    // Directed table: load-use, r0 load, branch over hazard, freeze with held branch.
    addVec(1, 16'h0, 0, 0, 0, C_RST,   0, 0, 0);
    addVec(1, 16'h0, 0, 0, 0, C_RST,   1, 0, 0);
    addVec(0, mk(4,1,2,0), 1, 0, 0, C_NORM,  1, 0, 0);
    addVec(0, mk(0,2,4,3), 1, 0, 0, C_STALL, 1, 0, 0);
    addVec(0, mk(0,2,4,3), 1, 0, 0, C_NORM,  1, 1, 0);
    addVec(0, mk(4,1,0,0), 1, 0, 0, C_NORM,  1, 1, 0);
    addVec(0, mk(0,0,4,3), 1, 0, 0, C_NORM,  1, 1, 0);
    addVec(0, mk(4,1,5,0), 1, 0, 0, C_NORM,  1, 1, 0);
    addVec(0, mk(0,5,4,3), 1, 1, 0, C_FLUSH, 1, 1, 0);
    addVec(0, mk(0,2,3,1), 1, 0, 0, C_NORM,  1, 1, 1);
    addVec(1, 16'h0, 0, 0, 0, C_RST,   0, 0, 0);
    addVec(1, 16'h0, 0, 0, 0, C_RST,   1, 0, 0);
    addVec(0, mk(4,1,6,0), 1, 1, 1, C_FRZ,   1, 0, 0);
    addVec(0, mk(4,1,6,0), 1, 1, 1, C_FRZ,   1, 0, 0);
    addVec(0, mk(4,1,6,0), 1, 1, 1, C_FRZ,   1, 0, 0);
    addVec(0, mk(4,1,6,0), 1, 1, 0, C_FLUSH, 1, 0, 0);
    addVec(0, mk(0,6,4,3), 1, 0, 0, C_NORM,  1, 0, 1);
    addVec(0, mk(4,1,6,0), 1, 0, 0, C_NORM,  1, 0, 1);
    addVec(0, mk(0,6,4,3), 1, 0, 1, C_FRZ,   1, 0, 1);
    addVec(0, mk(0,6,4,3), 1, 0, 0, C_STALL, 1, 0, 1);
    addVec(0, mk(0,6,4,3), 1, 0, 0, C_NORM,  1, 1, 1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].instr, vecs[i].valid, vecs[i].br, vecs[i].busy);
      checkOutput($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].chk_cnt, vecs[i].stall, vecs[i].flush);
    end

    // Halt reaches EX, controller halts one cycle later and ignores everything but rst.
    applyStimulus(1, 16'h0, 0, 0, 0); checkOutput("halt_rst0", C_RST, 0, 0, 0);
    applyStimulus(1, 16'h0, 0, 0, 0); checkOutput("halt_rst1", C_RST, 1, 0, 0);
    applyStimulus(0, mk(0,1,2,3), 1, 1, 0); checkOutput("halt_br", C_FLUSH, 1, 0, 0);
    applyStimulus(0, mk(15,0,0,0), 1, 0, 0); checkOutput("halt_id", C_NORM, 1, 0, 1);
    applyStimulus(0, mk(0,1,2,3), 1, 0, 0); checkOutput("halt_ex", C_NORM, 1, 0, 1);
    applyStimulus(0, mk(4,1,2,0), 1, 0, 0); checkOutput("halted", C_HALT, 1, 0, 1);
    applyStimulus(0, mk(0,2,4,3), 1, 1, 1); checkOutput("halted_hold", C_HALT, 1, 0, 1);
    applyStimulus(1, 16'h0, 0, 0, 0); checkOutput("halt_clr0", C_RST, 0, 0, 0);
    applyStimulus(1, 16'h0, 0, 0, 0); checkOutput("halt_clr1", C_RST, 1, 0, 0);
    applyStimulus(0, mk(0,1,2,3), 1, 0, 0); checkOutput("halt_resume", C_NORM, 1, 0, 0);

    // Counter saturation, with the counters preloaded near the top.
    applyStimulus(1, 16'h0, 0, 0, 0);
    applyStimulus(0, 16'h0, 0, 0, 0);
    force dut.stall_cnt = 16'hFFFD;
    force dut.flush_cnt = 16'hFFFE;
    #1;
    release dut.stall_cnt;
    release dut.flush_cnt;
    exp_s = 16'hFFFD;
    exp_f = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, mk(4,1,2,0), 1, 0, 0); checkOutput("sat_lw", C_NORM, 1, exp_s, exp_f);
      applyStimulus(0, mk(0,2,4,3), 1, 0, 0); checkOutput("sat_use", C_STALL, 1, exp_s, exp_f);
      if (exp_s != 16'hFFFF) exp_s = exp_s + 16'd1;
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, mk(0,2,4,3), 1, 1, 0); checkOutput("sat_br", C_FLUSH, 1, exp_s, exp_f);
      if (exp_f != 16'hFFFF) exp_f = exp_f + 16'd1;
    end
    applyStimulus(0, 16'h0, 0, 0, 0); checkOutput("sat_hold", C_NORM, 1, 16'hFFFF, 16'hFFFF);

    // Random traffic against the behavioural model.
    applyStimulus(1, 16'h0, 0, 0, 0);
    applyStimulus(1, 16'h0, 0, 0, 0);
    m_halt = 0; m_stall = 0; m_flush = 0; m_ex_ok = 1'b0; m_ex = '0;
    for (int n = 0; n < 2500; n++) begin
      int pick, op;
      pick = int'($urandom_range(0, 99));
      if (pick < 25)      op = 0;
      else if (pick < 42) op = 4;
      else if (pick < 50) op = 1;
      else if (pick < 55) op = 3;
      else if (pick < 65) op = 5;
      else if (pick < 75) op = 6;
      else if (pick < 77) op = 15;
      else                op = 7 + int'($urandom_range(0, 7));
      r_instr = mk(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      r_rst   = ($urandom_range(0, 59) == 0);
      r_valid = ($urandom_range(0, 9) != 0);
      r_br    = ($urandom_range(0, 9) == 0);
      r_busy  = ($urandom_range(0, 6) == 0);
      applyStimulus(r_rst, r_instr, r_valid, r_br, r_busy);

      mask = readMask(r_instr);
      hz   = r_valid && m_ex_ok && (m_ex[15:12] == 4'd4) && mask[m_ex[8:6]];
      if (r_rst)            exp_ctl = C_RST;
      else if (m_halt != 0) exp_ctl = C_HALT;
      else if (r_busy)      exp_ctl = C_FRZ;
      else if (r_br)        exp_ctl = C_FLUSH;
      else if (hz)          exp_ctl = C_STALL;
      else                  exp_ctl = C_NORM;
      checkOutput($sformatf("rand%0d", n), exp_ctl, 1, m_stall[15:0], m_flush[15:0]);

      @(posedge clk);
      if (r_rst) begin
        m_halt = 0; m_stall = 0; m_flush = 0; m_ex_ok = 1'b0; m_ex = '0;
      end else if (m_halt != 0) begin
        m_ex_ok = 1'b0;
      end else if (!r_busy) begin
        if (m_ex_ok && m_ex[15:12] == 4'd15) m_halt = 1;
        if (r_br) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
        else if (hz) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        m_ex_ok = r_valid && !r_br && !hz;
        m_ex    = r_instr;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
